word_serializer: RTL and testbench

WORD_SERIALIZER -- requirements
Module: word_serializer

---
 rtl/word_serializer.sv | 90 +++++++++
 tb/tb_word_serializer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/word_serializer.sv
// rtl/word_serializer.sv - 16-bit parallel-to-serial shifter with ready/valid serial output
// Per-word mode: MSB/LSB-first shift direction, zero or rotate fill.
module word_serializer (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [15:0] IN,
  input  logic [1:0]  SEL,
  input  logic        IN_VALID,
  output logic        IN_READY,
  output logic        SO,
  output logic        SO_VALID,
  input  logic        SO_READY,
  output logic        DONE,
  output logic [15:0] OUT
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] reg_q, reg_d;
  logic [1:0]  mode_q, mode_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        done_q, done_d;
  logic        fill;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= S_IDLE;
      reg_q   <= 16'h0000;
      mode_q  <= 2'b00;
      cnt_q   <= 4'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    fill    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (IN_VALID) begin
          reg_d   = IN;
          mode_d  = SEL;
          cnt_d   = 4'd0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (SO_READY) begin
          // Fill bit is the bit being shifted out when rotating, so 16 shifts restore the word.
          if (mode_q[0]) begin
            fill  = mode_q[1] & reg_q[0];
            reg_d = {fill, reg_q[15:1]};
          end else begin
            fill  = mode_q[1] & reg_q[15];
            reg_d = {reg_q[14:0], fill};
          end
          if (cnt_q == 4'd15) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign IN_READY = (state_q == S_IDLE);
  assign SO_VALID = (state_q == S_SHIFT);
  assign SO       = SO_VALID & (mode_q[0] ? reg_q[0] : reg_q[15]);
  assign DONE     = done_q;
  assign OUT      = reg_q;

endmodule

// File: tb/tb_word_serializer.sv
// tb/tb_word_serializer.sv - self-checking bench for word_serializer
// Table of words plus hand sequences; serial bits and DONE-time OUT are scoreboarded.
module tb_word_serializer;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [15:0] IN;
  logic [1:0]  SEL;
  logic        IN_VALID;
  logic        IN_READY;
  logic        SO;
  logic        SO_VALID;
  logic        SO_READY;
  logic        DONE;
  logic [15:0] OUT;

  word_serializer dut (
    .CLK(CLK), .RST_N(RST_N), .IN(IN), .SEL(SEL), .IN_VALID(IN_VALID),
    .IN_READY(IN_READY), .SO(SO), .SO_VALID(SO_VALID), .SO_READY(SO_READY),
    .DONE(DONE), .OUT(OUT)
  );

  always #5 CLK = ~CLK;

  // stream holds the expected serial bits, first-sent bit in position 15
  typedef struct {
    logic [15:0] in_word;
    logic [1:0]  sel;
    logic [15:0] stream;
    logic [15:0] out_exp;
    bit          stall;
  } vec_t;

  vec_t        vecs[6];
  int          checks = 0;
  int          errors = 0;
  bit          exp_bits[$];
  logic [15:0] exp_outs[$];
  int          done_count = 0;
  bit          mon_en = 1'b0;
  bit          prev_stall = 1'b0;
  logic        prev_so = 1'b0;
  bit          mon_bit;
  logic [15:0] mon_out;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: got event missing expected event present", nm);
  endtask

  task automatic load(input logic [15:0] w, input logic [1:0] s, input logic [15:0] stream);
    IN = w;
    SEL = s;
    IN_VALID = 1'b1;
    for (int i = 15; i >= 0; i--) exp_bits.push_back(stream[i]);
  endtask

  task automatic wait_done(input int bound, input bit alt, input bit junk, output int n);
    bit seen;
    seen = 1'b0;
    n = 0;
    while (n < bound && !seen) begin
      @(posedge CLK); #1;
      n++;
      if (DONE) seen = 1'b1;
      else begin
        if (alt) SO_READY = ~SO_READY;
        if (junk) begin
          IN  = 16'($urandom);
          SEL = 2'($urandom_range(3));
        end
      end
    end
    if (!seen) fail_now("done_timeout");
  endtask

  task automatic b2b(input logic [15:0] w1, input logic [1:0] s1, input logic [15:0] st1,
                     input logic [15:0] o1, input logic [15:0] w2, input logic [1:0] s2,
                     input logic [15:0] st2, input logic [15:0] o2, input bit junk);
    int n1, n2, d0;
    SO_READY = 1'b1;
    load(w1, s1, st1);
    exp_outs.push_back(o1);
    @(posedge CLK); #1;
    IN_VALID = junk;
    d0 = done_count;
    wait_done(40, 1'b0, junk, n1);
    load(w2, s2, st2);
    exp_outs.push_back(o2);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    wait_done(40, 1'b0, 1'b0, n2);
    chk("b2b_latency", n1 + 1 + n2 + 1, 34);
    chk("b2b_bits_consumed", exp_bits.size(), 0);
    @(posedge CLK); #1;
    chk("b2b_done_count", done_count - d0, 2);
  endtask

  // Monitor: samples on the falling edge, inputs change #1 after the rising edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (mon_en) begin
        if (SO_VALID && prev_stall) chk("so_stall_hold", int'(SO), int'(prev_so));
        if (SO_VALID && SO_READY) begin
          if (exp_bits.size() == 0) fail_now("so_unexpected_transfer");
          else begin
            mon_bit = exp_bits.pop_front();
            chk("so_bit", int'(SO), int'(mon_bit));
          end
        end
        if (!SO_VALID) chk("so_idle_zero", int'(SO), 0);
        if (DONE) begin
          done_count++;
          chk("done_in_ready", int'(IN_READY), 1);
          if (exp_outs.size() == 0) fail_now("done_unexpected");
          else begin
            mon_out = exp_outs.pop_front();
            chk("out_at_done", int'(OUT), int'(mon_out));
          end
        end
        prev_stall = SO_VALID && !SO_READY;
        prev_so = SO;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0;
    vecs[0] = '{16'hA5C3, 2'b00, 16'hA5C3, 16'h0000, 1'b0};
    vecs[1] = '{16'h8001, 2'b11, 16'h8001, 16'h8001, 1'b0};
    vecs[2] = '{16'h00FF, 2'b01, 16'hFF00, 16'h0000, 1'b1};
    vecs[3] = '{16'h1234, 2'b10, 16'h1234, 16'h1234, 1'b0};
    vecs[4] = '{16'h0001, 2'b01, 16'h8000, 16'h0000, 1'b0};
    vecs[5] = '{16'h6003, 2'b11, 16'hC006, 16'h6003, 1'b1};

    RST_N = 1'b0;
    IN = 16'hFFFF;
    SEL = 2'b11;
    IN_VALID = 1'b1;
    SO_READY = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_in_ready", int'(IN_READY), 1);
    chk("rst_so_valid", int'(SO_VALID), 0);
    chk("rst_so", int'(SO), 0);
    chk("rst_out", int'(OUT), 0);
    chk("rst_done", int'(DONE), 0);
    RST_N = 1'b1;
    IN_VALID = 1'b0;
    mon_en = 1'b1;
    @(posedge CLK); #1;

    for (int i = 0; i < 6; i++) begin
      load(vecs[i].in_word, vecs[i].sel, vecs[i].stream);
      exp_outs.push_back(vecs[i].out_exp);
      SO_READY = !vecs[i].stall;
      @(posedge CLK); #1;
      IN_VALID = 1'b0;
      chk("load_in_ready_low", int'(IN_READY), 0);
      chk("load_so_valid", int'(SO_VALID), 1);
      d0 = done_count;
      wait_done(80, vecs[i].stall, 1'b0, n);
      if (!vecs[i].stall) chk("word_latency", n + 1, 17);
      chk("bits_consumed", exp_bits.size(), 0);
      @(posedge CLK); #1;
      chk("done_one_pulse", int'(DONE), 0);
      chk("done_count", done_count - d0, 1);
    end

    b2b(16'hC3A5, 2'b00, 16'hC3A5, 16'h0000, 16'h5A3C, 2'b01, 16'h3C5A, 16'h0000, 1'b1);
    b2b(16'h1234, 2'b00, 16'h1234, 16'h0000, 16'h1234, 2'b01, 16'h2C48, 16'h0000, 1'b0);

    SO_READY = 1'b1;
    load(16'hFFFF, 2'b00, 16'hFFFF);
    @(posedge CLK); #1;
    IN_VALID = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    chk("mid_out_after5", int'(OUT), int'(16'hFFE0));
    d0 = done_count;
    RST_N = 1'b0;
    SO_READY = 1'b0;
    IN_VALID = 1'b1;
    @(posedge CLK); #1;
    RST_N = 1'b1;
    IN_VALID = 1'b0;
    chk("abort_in_ready", int'(IN_READY), 1);
    chk("abort_so_valid", int'(SO_VALID), 0);
    chk("abort_out", int'(OUT), 0);
    chk("abort_done", int'(DONE), 0);
    chk("abort_bits_left", exp_bits.size(), 11);
    exp_bits.delete();
    repeat (3) @(posedge CLK);
    #1;
    chk("abort_no_done", done_count - d0, 0);
    chk("abort_stays_idle", int'(IN_READY), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
